// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: iterative shift-add multiplier that owns the HI/LO pair.
// Started by mult/multu (start) and retires BITS_PER_CYC multiplier bits per RUN cycle.
// It writes the 2*WIDTH product into HI/LO, serves mfhi/mflo reads, and raises stall
// when a read or a new start arrives while a multiply is in flight.
// Optional feature macro: HILO_EARLY_TERM_EN finishes as soon as the remaining multiplier is zero.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   start, is_signed  begin multiply; 1 = mult, 0 = multu (sampled with start)
//   op_a, op_b        multiplicand / multiplier (sampled with start)
//   rd_req, rd_sel    mfhi/mflo in EX; rd_sel 01 = HI, 10 = LO
//   rd_data           combinational read data (0 for other rd_sel codes)
//   hi, lo            architectural HI/LO registers
//   busy, done        state is RUN / one-cycle pulse after HI/LO update
//   stall             combinational: (start | rd_req) & busy
module hilo_mult_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned STEPS = WIDTH / BITS_PER_CYC;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic [PW-1:0]      partial_c, acc_sum_c, prod_c;
  logic [WIDTH-1:0]   mplier_nxt_c;
  logic               last_c;

  // Operand magnitudes for the accepting cycle.
  assign a_mag_c = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag_c = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // Partial product of the pre-shifted multiplicand and the current multiplier digit.
  always_comb begin
    partial_c = '0;
    for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
      if (mplier_q[j]) partial_c = partial_c + (mcand_q << j);
    end
  end

  assign acc_sum_c    = acc_q + partial_c;
  assign prod_c       = neg_q ? -acc_sum_c : acc_sum_c;
  assign mplier_nxt_c = mplier_q >> BITS_PER_CYC;

`ifdef HILO_EARLY_TERM_EN
  // No set bits left above this digit: the accumulator is already final.
  assign last_c = (cnt_q == '0) || (mplier_nxt_c == '0);
`else
  assign last_c = (cnt_q == '0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = PW'(a_mag_c);
          mplier_d = b_mag_c;
          neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(STEPS - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << BITS_PER_CYC;
        mplier_d = mplier_nxt_c;
        cnt_d    = cnt_q - CNT_W'(1);
        if (last_c) begin
          {hi_d, lo_d} = prod_c;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign stall = (start | rd_req) & busy;

  // Read mux; during RUN this shows stale HI/LO, which the stall keeps from committing.
  always_comb begin
    case (rd_sel)
      2'b01:   rd_data = hi_q;
      2'b10:   rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

endmodule
